fpdiv_issue_seq: RTL and testbench

//   Operand-issue sequencer directly upstream of the fpdiv divider. Buffers {A,B} operand

---
 rtl/fpdiv_issue_seq.sv | 203 ++++++++++++++++++++
 tb/tb_fpdiv_issue_seq.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpdiv_issue_seq.sv
// fpdiv_issue_seq: operand-issue sequencer in front of the fpdiv divider.
// Buffers {A,B} pairs in a FIFO, issues them one at a time with a clean start
// edge, waits for DONE and presents the quotient on a valid/ready port.
// Optional build macro: FPDIV_SEQ_TIMEOUT_EN (bounded WAIT with forced result).
module fpdiv_issue_seq #(
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned SETTLE_CYCLES  = 2,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                     CLOCK,
    input  logic                     RESET,
    input  logic                     IN_VALID,
    output logic                     IN_READY,
    input  logic [31:0]              IN_A,
    input  logic [31:0]              IN_B,
    output logic [31:0]              DIV_A,
    output logic [31:0]              DIV_B,
    output logic                     DIV_START,
    input  logic                     DIV_DONE,
    input  logic [31:0]              DIV_RESULT,
    input  logic [1:0]               DIV_EXC,
    output logic                     OUT_VALID,
    input  logic                     OUT_READY,
    output logic [31:0]              OUT_RESULT,
    output logic [1:0]               OUT_EXC,
    output logic                     OUT_TIMEOUT,
    output logic                     BUSY,
    output logic [$clog2(DEPTH):0]   LEVEL
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;
    localparam int unsigned SW = $clog2(SETTLE_CYCLES) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FIRE,
        S_SETTLE,
        S_WAIT,
        S_OUT
    } state_e;

    state_e           state_q;
    logic [31:0]      mem_a_q [DEPTH];
    logic [31:0]      mem_b_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic [31:0]      div_a_q;
    logic [31:0]      div_b_q;
    logic             div_start_q;
    logic             out_valid_q;
    logic [31:0]      out_result_q;
    logic [1:0]       out_exc_q;
    logic             busy_q;
    logic [SW-1:0]    settle_cnt_q;
    logic             pop_c;
    logic             push_c;

    // A pop happens whenever the FSM idles with data queued; a push while
    // full is accepted only when that pop frees the slot in the same cycle.
    assign pop_c    = (state_q == S_IDLE) && (level_q != '0);
    assign IN_READY = (level_q != LW'(DEPTH)) || pop_c;
    assign push_c   = IN_VALID && IN_READY;

    assign DIV_A      = div_a_q;
    assign DIV_B      = div_b_q;
    assign DIV_START  = div_start_q;
    assign OUT_VALID  = out_valid_q;
    assign OUT_RESULT = out_result_q;
    assign OUT_EXC    = out_exc_q;
    assign BUSY       = busy_q;
    assign LEVEL      = level_q;

    // Operand FIFO storage, pointers and occupancy.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_a_q[i] <= '0;
                mem_b_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_c) begin
                mem_a_q[wr_ptr_q] <= IN_A;
                mem_b_q[wr_ptr_q] <= IN_B;
                wr_ptr_q          <= wr_ptr_q + PW'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push_c, pop_c})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

`ifdef FPDIV_SEQ_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TW-1:0] wait_cnt_q;
    logic          out_timeout_q;
    assign OUT_TIMEOUT = out_timeout_q;
`else
    logic unused_timeout_cfg;
    // Timeout depth has no function in this build.
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign OUT_TIMEOUT        = 1'b0;
`endif

    // Issue FSM: pop, present operands, raise start, settle, wait, hand off.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q       <= S_IDLE;
            div_a_q       <= '0;
            div_b_q       <= '0;
            div_start_q   <= 1'b0;
            out_valid_q   <= 1'b0;
            out_result_q  <= '0;
            out_exc_q     <= '0;
            busy_q        <= 1'b0;
            settle_cnt_q  <= '0;
`ifdef FPDIV_SEQ_TIMEOUT_EN
            wait_cnt_q    <= '0;
            out_timeout_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop_c) begin
                        div_a_q     <= mem_a_q[rd_ptr_q];
                        div_b_q     <= mem_b_q[rd_ptr_q];
                        div_start_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    div_start_q <= 1'b0;
                    state_q     <= S_FIRE;
                end
                S_FIRE: begin
                    div_start_q  <= 1'b1;
                    settle_cnt_q <= '0;
                    state_q      <= S_SETTLE;
                end
                S_SETTLE: begin
                    // DONE may still be stale from the previous divide here.
                    if (settle_cnt_q == SW'(SETTLE_CYCLES - 1)) begin
                        state_q <= S_WAIT;
`ifdef FPDIV_SEQ_TIMEOUT_EN
                        wait_cnt_q <= '0;
`endif
                    end else begin
                        settle_cnt_q <= settle_cnt_q + SW'(1);
                    end
                end
                S_WAIT: begin
                    if (DIV_DONE) begin
                        out_result_q <= DIV_RESULT;
                        out_exc_q    <= DIV_EXC;
                        out_valid_q  <= 1'b1;
                        div_start_q  <= 1'b0;
                        state_q      <= S_OUT;
                    end
`ifdef FPDIV_SEQ_TIMEOUT_EN
                    else if (wait_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        out_result_q  <= 32'h7FFF_FFFF;
                        out_exc_q     <= 2'b11;
                        out_timeout_q <= 1'b1;
                        out_valid_q   <= 1'b1;
                        div_start_q   <= 1'b0;
                        state_q       <= S_OUT;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + TW'(1);
                    end
`endif
                end
                S_OUT: begin
                    if (OUT_READY) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
`ifdef FPDIV_SEQ_TIMEOUT_EN
                        out_timeout_q <= 1'b0;
`endif
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    div_start_q <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpdiv_issue_seq.sv
// Directed bench for fpdiv_issue_seq with a behavioural divider stand-in.
module tb_fpdiv_issue_seq;

    logic        CLOCK;
    logic        RESET;
    logic        IN_VALID;
    logic        IN_READY;
    logic [31:0] IN_A;
    logic [31:0] IN_B;
    logic [31:0] DIV_A;
    logic [31:0] DIV_B;
    logic        DIV_START;
    logic        DIV_DONE;
    logic [31:0] DIV_RESULT;
    logic [1:0]  DIV_EXC;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] OUT_RESULT;
    logic [1:0]  OUT_EXC;
    logic        OUT_TIMEOUT;
    logic        BUSY;
    logic [2:0]  LEVEL;

    int n_cmp = 0;
    int n_err = 0;
    int lat   = 0;   // stand-in latency after it sees the start edge; <0 never answers

    fpdiv_issue_seq dut (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .IN_VALID   (IN_VALID),
        .IN_READY   (IN_READY),
        .IN_A       (IN_A),
        .IN_B       (IN_B),
        .DIV_A      (DIV_A),
        .DIV_B      (DIV_B),
        .DIV_START  (DIV_START),
        .DIV_DONE   (DIV_DONE),
        .DIV_RESULT (DIV_RESULT),
        .DIV_EXC    (DIV_EXC),
        .OUT_VALID  (OUT_VALID),
        .OUT_READY  (OUT_READY),
        .OUT_RESULT (OUT_RESULT),
        .OUT_EXC    (OUT_EXC),
        .OUT_TIMEOUT(OUT_TIMEOUT),
        .BUSY       (BUSY),
        .LEVEL      (LEVEL)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    // Divider answers: hand-known quotients, otherwise a recognisable pattern.
    function automatic logic [33:0] div_answer(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h40A0_0000 && b == 32'h4000_0000) return {2'b00, 32'h4020_0000};
        if (b == 32'h0000_0000)                      return {2'b00, 32'h7F80_0000};
        return {a[1:0], a ^ b};
    endfunction

    // Divider stand-in: DONE stays high from the last op until it sees a new start edge.
    logic start_prev;
    int   cnt;
    always @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            start_prev <= 1'b0;
            DIV_DONE   <= 1'b0;
            DIV_RESULT <= '0;
            DIV_EXC    <= '0;
            cnt        <= 0;
        end else begin
            start_prev <= DIV_START;
            if (DIV_START && !start_prev) begin
                if (lat == 0) begin
                    DIV_DONE              <= 1'b1;
                    {DIV_EXC, DIV_RESULT} <= div_answer(DIV_A, DIV_B);
                end else begin
                    DIV_DONE <= 1'b0;
                    cnt      <= (lat < 0) ? 0 : lat;
                end
            end else if (cnt > 0) begin
                cnt <= cnt - 1;
                if (cnt == 1) begin
                    DIV_DONE              <= 1'b1;
                    {DIV_EXC, DIV_RESULT} <= div_answer(DIV_A, DIV_B);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Offer one pair from a falling edge and hold it until accepted.
    task automatic push(input logic [31:0] a, input logic [31:0] b);
        int w;
        @(negedge CLOCK);
        IN_VALID = 1'b1;
        IN_A     = a;
        IN_B     = b;
        w = 0;
        while (!IN_READY && w < 200) begin
            @(negedge CLOCK);
            w++;
        end
        if (w >= 200) chk("push_accept_bound", 32'd0, 32'd1);
        @(posedge CLOCK);
        #1;
        IN_VALID = 1'b0;
    endtask

    // One complete op with OUT_READY high; checks timing and captured result.
    task automatic run_one(input string tag, input int l, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] er,
                           input logic [1:0] ee, input int edelta);
        int t_busy, t_start, t_valid;
        lat       = l;
        OUT_READY = 1'b1;
        push(a, b);
        t_busy = -1; t_start = -1; t_valid = -1;
        for (int c = 0; c < 300 && t_valid < 0; c++) begin
            @(negedge CLOCK);
            if (BUSY && t_busy < 0)       t_busy  = c;
            if (DIV_START && t_start < 0) t_start = c;
            if (OUT_VALID)                t_valid = c;
        end
        chk({tag, "_valid_seen"}, 32'(t_valid >= 0), 32'd1);
        chk({tag, "_pop_to_start"}, 32'(t_start - t_busy), 32'd2);
        chk({tag, "_start_to_valid"}, 32'(t_valid - t_start), 32'(edelta));
        chk({tag, "_result"}, OUT_RESULT, er);
        chk({tag, "_exc"}, 32'(OUT_EXC), 32'(ee));
        chk({tag, "_start_low"}, 32'(DIV_START), 32'd0);
        chk({tag, "_div_a"}, DIV_A, a);
        chk({tag, "_div_b"}, DIV_B, b);
        chk({tag, "_timeout_flag"}, 32'(OUT_TIMEOUT), 32'd0);
        @(posedge CLOCK);
        #1;
        chk({tag, "_valid_cleared"}, 32'(OUT_VALID), 32'd0);
        chk({tag, "_idle"}, 32'(BUSY), 32'd0);
    endtask

    logic [31:0] bp_a [6];
    logic [31:0] bp_b [6];
    logic [33:0] ans;
    int          k;
    int          t_start, t_valid;

    initial begin
        RESET     = 1'b0;
        IN_VALID  = 1'b0;
        IN_A      = '0;
        IN_B      = '0;
        OUT_READY = 1'b0;
        repeat (3) @(negedge CLOCK);
        chk("rst_div_start", 32'(DIV_START), 32'd0);
        chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
        chk("rst_level", 32'(LEVEL), 32'd0);
        chk("rst_in_ready", 32'(IN_READY), 32'd1);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_out_result", OUT_RESULT, 32'd0);
        chk("rst_out_exc", 32'(OUT_EXC), 32'd0);
        chk("rst_div_a", DIV_A, 32'd0);
        chk("rst_timeout", 32'(OUT_TIMEOUT), 32'd0);
        RESET = 1'b1;
        @(negedge CLOCK);

        // 5/2 with a 4-cycle divider: capture 6 cycles after the start edge.
        run_one("norm", 4, 32'h40A0_0000, 32'h4000_0000, 32'h4020_0000, 2'b00, 6);
        // 5/0 answers at once (stale DONE from 5/2 must be ignored): SETTLE+1.
        run_one("div0", 0, 32'h40A0_0000, 32'h0000_0000, 32'h7F80_0000, 2'b00, 3);

        // Back-pressure: consumer stalled, six pairs offered back to back.
        lat       = 0;
        OUT_READY = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bp_a[i] = 32'h3F80_0000 | 32'(i);
            bp_b[i] = 32'h4000_0000 | 32'(i << 4);
        end
        for (int i = 0; i < 5; i++) push(bp_a[i], bp_b[i]);
        repeat (20) @(negedge CLOCK);
        ans = div_answer(bp_a[0], bp_b[0]);
        chk("bp_level_full", 32'(LEVEL), 32'd4);
        chk("bp_in_ready_low", 32'(IN_READY), 32'd0);
        chk("bp_out_valid", 32'(OUT_VALID), 32'd1);
        chk("bp_result0", OUT_RESULT, ans[31:0]);
        chk("bp_exc0", 32'(OUT_EXC), 32'(ans[33:32]));
        IN_VALID = 1'b1;
        IN_A     = bp_a[5];
        IN_B     = bp_b[5];
        repeat (3) @(negedge CLOCK);
        chk("bp_sixth_held", 32'(IN_READY), 32'd0);
        chk("bp_level_held", 32'(LEVEL), 32'd4);
        chk("bp_result_stable", OUT_RESULT, ans[31:0]);
        OUT_READY = 1'b1;
        @(negedge CLOCK);
        chk("pp_ready_on_pop", 32'(IN_READY), 32'd1);
        chk("pp_level_before", 32'(LEVEL), 32'd4);
        @(posedge CLOCK);
        #1;
        IN_VALID = 1'b0;
        @(negedge CLOCK);
        chk("pp_level_after", 32'(LEVEL), 32'd4);
        k = 1;
        for (int c = 0; c < 400 && k < 6; c++) begin
            @(negedge CLOCK);
            if (OUT_VALID) begin
                ans = div_answer(bp_a[k], bp_b[k]);
                chk($sformatf("bp_result%0d", k), OUT_RESULT, ans[31:0]);
                k++;
            end
        end
        chk("bp_count", 32'(k), 32'd6);
        repeat (2) @(negedge CLOCK);
        chk("bp_drained", 32'(LEVEL), 32'd0);

        // Reset while waiting on a divider that never answers.
        lat = -1;
        push(32'h4110_0000, 32'h4040_0000);
        repeat (10) @(negedge CLOCK);
        push(32'h1111_1111, 32'h2222_2222);
        push(32'h3333_3333, 32'h4444_4444);
        @(negedge CLOCK);
        chk("mid_start_high", 32'(DIV_START), 32'd1);
        chk("mid_level", 32'(LEVEL), 32'd2);
        RESET = 1'b0;
        #1;
        chk("mid_rst_start", 32'(DIV_START), 32'd0);
        chk("mid_rst_level", 32'(LEVEL), 32'd0);
        chk("mid_rst_valid", 32'(OUT_VALID), 32'd0);
        chk("mid_rst_busy", 32'(BUSY), 32'd0);
        @(negedge CLOCK);
        RESET = 1'b1;
        run_one("post_rst", 0, 32'h40A0_0000, 32'h4000_0000, 32'h4020_0000, 2'b00, 3);

        // Divider stuck: bounded by timeout only when the feature is built.
        lat       = -1;
        OUT_READY = 1'b1;
        push(32'h4000_0000, 32'h3F80_0000);
        t_start = -1; t_valid = -1;
        for (int c = 0; c < 200 && t_valid < 0; c++) begin
            @(negedge CLOCK);
            if (DIV_START && t_start < 0) t_start = c;
            if (OUT_VALID)                t_valid = c;
        end
`ifdef FPDIV_SEQ_TIMEOUT_EN
        chk("to_valid_seen", 32'(t_valid >= 0), 32'd1);
        chk("to_start_to_valid", 32'(t_valid - t_start), 32'd66);
        chk("to_result", OUT_RESULT, 32'h7FFF_FFFF);
        chk("to_exc", 32'(OUT_EXC), 32'd3);
        chk("to_flag", 32'(OUT_TIMEOUT), 32'd1);
        chk("to_start_low", 32'(DIV_START), 32'd0);
        @(posedge CLOCK);
        #1;
        chk("to_flag_cleared", 32'(OUT_TIMEOUT), 32'd0);
        chk("to_valid_cleared", 32'(OUT_VALID), 32'd0);
`else
        chk("stuck_no_valid", 32'(t_valid), 32'hFFFF_FFFF);
        chk("stuck_busy", 32'(BUSY), 32'd1);
        chk("stuck_timeout_flag", 32'(OUT_TIMEOUT), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
